// File: rtl/sru_trig_pkg.sv
// ---------------------------------------------------------------------------
// sru_trig_pkg
// Shared definitions for the test-trigger burst scheduler.
//   - burst_state_t : FSM state encoding (IDLE, CHECK, ISSUE, GAP, DONE)
//   - CNT_W_DEF     : default width of count, gap and statistics fields
//   - SAT_ALL_ONES  : saturation value for a default-width counter
//   - all_ones()    : saturation value for a counter of any width up to 32
// ---------------------------------------------------------------------------
package sru_trig_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [CNT_W_DEF-1:0] SAT_ALL_ONES = {CNT_W_DEF{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ISSUE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } burst_state_t;

   // All-ones value of the requested width, right-aligned in 32 bits.
   function automatic logic [31:0] all_ones(input int width);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/test_trig_burst_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up-counter with synchronous clear and saturation at all-ones.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears the count
//   clr    : synchronous clear (lower priority than reset)
//   inc    : increment request; ignored once the count is all-ones
//   count  : registered count value
// ---------------------------------------------------------------------------
module sat_counter
   import sru_trig_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [31:0]      MAX_32  = all_ones(CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = MAX_32[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;

   // Count register: clear wins over increment, increment stops at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (inc && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/test_trig_burst_ctrl.sv
// ---------------------------------------------------------------------------
// test_trig_burst_ctrl
// Burst scheduler for the test trigger generator. On an accepted start it
// issues burst_count strig_cmd pulses spaced by burst_gap, holding each pulse
// off while BusyFlag is high, and reports progress and statistics.
// Ports:
//   gclk_40m      : clock, rising edge
//   reset         : synchronous active-high reset
//   burst_start   : one-cycle start request (honoured only in IDLE)
//   burst_abort   : one-cycle abort request (honoured in CHECK/ISSUE/GAP)
//   burst_count   : triggers to issue, latched on accepted start
//   burst_gap     : gap setting, latched on accepted start
//   BusyFlag      : readout busy, holds off the next trigger
//   strig_cmd     : one-cycle software trigger pulse
//   burst_active  : burst in progress
//   burst_done    : one-cycle end-of-burst pulse (normal or aborted)
//   burst_aborted : sticky abort flag, cleared by the next accepted start
//   trig_issued   : pulses issued in the current or last burst
//   busy_stall    : cycles held off by BusyFlag, saturating
// All outputs are registered decodes of the state one cycle earlier, so
// strig_cmd appears two edges after the start is sampled.
// ---------------------------------------------------------------------------
module test_trig_burst_ctrl
   import sru_trig_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             gclk_40m,
   input  logic             reset,
   input  logic             burst_start,
   input  logic             burst_abort,
   input  logic [CNT_W-1:0] burst_count,
   input  logic [CNT_W-1:0] burst_gap,
   input  logic             BusyFlag,
   output logic             strig_cmd,
   output logic             burst_active,
   output logic             burst_done,
   output logic             burst_aborted,
   output logic [CNT_W-1:0] trig_issued,
   output logic [CNT_W-1:0] busy_stall
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   burst_state_t     state_r;
   burst_state_t     state_s;
   logic             start_acc_s;
   logic             abort_acc_s;
   logic             busy_inc_s;

   logic [CNT_W-1:0] gap_r;
   logic [CNT_W-1:0] remain_r;
   logic [CNT_W-1:0] gap_cnt_r;
   logic [CNT_W-1:0] trig_cnt_r;
   logic             aborted_r;
   logic             strig_r;
   logic             active_r;
   logic             done_r;

   // Next-state decode; abort overrides every other transition in CHECK/ISSUE/GAP.
   always_comb begin
      state_s     = state_r;
      start_acc_s = 1'b0;
      abort_acc_s = 1'b0;
      busy_inc_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (burst_start) begin
               start_acc_s = 1'b1;
               if (burst_count != CNT_ZERO) begin
                  state_s = ST_CHECK;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (burst_abort) begin
               abort_acc_s = 1'b1;
               state_s     = ST_DONE;
            end else if (BusyFlag) begin
               busy_inc_s  = 1'b1;
               state_s     = ST_CHECK;
            end else begin
               state_s     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (burst_abort) begin
               abort_acc_s = 1'b1;
               state_s     = ST_DONE;
            end else begin
               state_s     = ST_GAP;
            end
         end
         ST_GAP: begin
            if (burst_abort) begin
               abort_acc_s = 1'b1;
               state_s     = ST_DONE;
            end else if (gap_cnt_r == gap_r) begin
               if (remain_r == CNT_ZERO) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_CHECK;
               end
            end else begin
               state_s = ST_GAP;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge gclk_40m) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Burst parameters latched on accepted start; remaining count drops per issued pulse.
   always_ff @(posedge gclk_40m) begin
      if (reset) begin
         gap_r    <= CNT_ZERO;
         remain_r <= CNT_ZERO;
      end else if (start_acc_s) begin
         gap_r    <= burst_gap;
         remain_r <= burst_count;
      end else if (state_r == ST_ISSUE) begin
         gap_r    <= gap_r;
         remain_r <= remain_r - CNT_ONE;
      end else begin
         gap_r    <= gap_r;
         remain_r <= remain_r;
      end
   end

   // Gap counter restarts at each issued pulse and runs up to the latched gap.
   always_ff @(posedge gclk_40m) begin
      if (reset) begin
         gap_cnt_r <= CNT_ZERO;
      end else if (start_acc_s || (state_r == ST_ISSUE)) begin
         gap_cnt_r <= CNT_ZERO;
      end else if ((state_r == ST_GAP) && (gap_cnt_r != gap_r)) begin
         gap_cnt_r <= gap_cnt_r + CNT_ONE;
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   // Issued-trigger count; bounded by the latched count so no wrap is possible.
   always_ff @(posedge gclk_40m) begin
      if (reset) begin
         trig_cnt_r <= CNT_ZERO;
      end else if (start_acc_s) begin
         trig_cnt_r <= CNT_ZERO;
      end else if (state_r == ST_ISSUE) begin
         trig_cnt_r <= trig_cnt_r + CNT_ONE;
      end else begin
         trig_cnt_r <= trig_cnt_r;
      end
   end

   // Sticky abort flag: set on an honoured abort, cleared by the next accepted start.
   always_ff @(posedge gclk_40m) begin
      if (reset) begin
         aborted_r <= 1'b0;
      end else if (start_acc_s) begin
         aborted_r <= 1'b0;
      end else if (abort_acc_s) begin
         aborted_r <= 1'b1;
      end else begin
         aborted_r <= aborted_r;
      end
   end

   // Registered status pulses decoded from the current state.
   always_ff @(posedge gclk_40m) begin
      if (reset) begin
         strig_r  <= 1'b0;
         active_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         strig_r  <= (state_r == ST_ISSUE);
         active_r <= (state_r == ST_CHECK) || (state_r == ST_ISSUE) || (state_r == ST_GAP);
         done_r   <= (state_r == ST_DONE);
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_busy_stall (
      .clk   (gclk_40m),
      .reset (reset),
      .clr   (start_acc_s),
      .inc   (busy_inc_s),
      .count (busy_stall)
   );

   assign strig_cmd     = strig_r;
   assign burst_active  = active_r;
   assign burst_done    = done_r;
   assign burst_aborted = aborted_r;
   assign trig_issued   = trig_cnt_r;

endmodule

// File: tb/tb_test_trig_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_test_trig_burst_ctrl
// Directed scenarios push expected strig_cmd / burst_done events (edge number
// relative to the start edge plus status values) into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever the DUT pulses.
// ---------------------------------------------------------------------------
module tb_test_trig_burst_ctrl;

   localparam int CW = 16;

   logic          gclk_40m;
   logic          reset;
   logic          burst_start;
   logic          burst_abort;
   logic [CW-1:0] burst_count;
   logic [CW-1:0] burst_gap;
   logic          BusyFlag;
   logic          strig_cmd;
   logic          burst_active;
   logic          burst_done;
   logic          burst_aborted;
   logic [CW-1:0] trig_issued;
   logic [CW-1:0] busy_stall;

   typedef struct {
      int kind;   // 0 = strig_cmd, 1 = burst_done
      int edge_n; // absolute edge number at which the pulse goes high
      int trig;
      int busy;
      int abrt;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt    = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   s_edge      = 0;
   logic active_seen = 1'b0;

   test_trig_burst_ctrl #(.CNT_W(CW)) dut (
      .gclk_40m      (gclk_40m),
      .reset         (reset),
      .burst_start   (burst_start),
      .burst_abort   (burst_abort),
      .burst_count   (burst_count),
      .burst_gap     (burst_gap),
      .BusyFlag      (BusyFlag),
      .strig_cmd     (strig_cmd),
      .burst_active  (burst_active),
      .burst_done    (burst_done),
      .burst_aborted (burst_aborted),
      .trig_issued   (trig_issued),
      .busy_stall    (busy_stall)
   );

   initial gclk_40m = 1'b0;
   always #12 gclk_40m = ~gclk_40m;

   // Edge counter: after rising edge E the value reads E.
   always @(posedge gclk_40m) edge_cnt <= edge_cnt + 1;

   // Monitor: compare every output pulse with the head of the scoreboard.
   always @(negedge gclk_40m) begin
      exp_t e;
      int   kind;
      if (burst_active) active_seen = 1'b1;
      if (strig_cmd || burst_done) begin
         kind = strig_cmd ? 0 : 1;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: got strig=%0b done=%0b at edge %0d, required no pulse",
                     strig_cmd, burst_done, edge_cnt);
         end else begin
            e = sb.pop_front();
            if (kind != e.kind || edge_cnt != e.edge_n || int'(trig_issued) != e.trig ||
                int'(busy_stall) != e.busy || int'(burst_aborted) != e.abrt) begin
               miscompares++;
               $display("FAIL pulse_event: got kind=%0d edge=%0d trig=%0d busy=%0d abrt=%0b, required kind=%0d edge=%0d trig=%0d busy=%0d abrt=%0d",
                        kind, edge_cnt, trig_issued, busy_stall, burst_aborted,
                        e.kind, e.edge_n, e.trig, e.busy, e.abrt);
            end
         end
      end
   end

   // Watchdog: the run must never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int rel, input int trig, input int busy, input int abrt);
      exp_t e;
      e.kind = kind; e.edge_n = s_edge + rel; e.trig = trig; e.busy = busy; e.abrt = abrt;
      sb.push_back(e);
   endtask

   // Drive a start so that it is sampled at the next rising edge; records that edge.
   task automatic start_burst(input int cnt, input int gap);
      @(negedge gclk_40m);
      burst_count = CW'(cnt);
      burst_gap   = CW'(gap);
      burst_start = 1'b1;
      s_edge      = edge_cnt + 1;
   endtask

   task automatic release_start();
      @(negedge gclk_40m);
      burst_start = 1'b0;
   endtask

   // Advance to the falling edge just before absolute rising edge e.
   task automatic to_before_edge(input int e);
      do @(negedge gclk_40m); while (edge_cnt < e - 1);
   endtask

   // Wait for the scoreboard to drain, then idle a few cycles to catch stray pulses.
   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge gclk_40m);
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL %s_timeout: got %0d pending events, required 0", name, sb.size());
         sb.delete();
      end
      repeat (6) @(posedge gclk_40m);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_strig"},  int'(strig_cmd),     0);
      check({name, "_active"}, int'(burst_active),  0);
      check({name, "_done"},   int'(burst_done),    0);
      check({name, "_abrt"},   int'(burst_aborted), 0);
      check({name, "_trig"},   int'(trig_issued),   0);
      check({name, "_busy"},   int'(busy_stall),    0);
   endtask

   initial begin
      reset       = 1'b1;
      burst_start = 1'b0;
      burst_abort = 1'b0;
      burst_count = '0;
      burst_gap   = '0;
      BusyFlag    = 1'b0;
      repeat (3) @(negedge gclk_40m);
      check_all_zero("reset_state");
      reset = 1'b0;
      repeat (2) @(negedge gclk_40m);

      // 1: count 3, gap 10, no busy: pulses every 13 edges, done gap+2 after the last.
      start_burst(3, 10);
      push(0, 2, 1, 0, 0); push(0, 15, 2, 0, 0); push(0, 28, 3, 0, 0); push(1, 40, 3, 0, 0);
      release_start();
      drain("basic", 80);

      // 2: count 2, gap 4, BusyFlag high for edges S..S+19.
      BusyFlag = 1'b1;
      start_burst(2, 4);
      push(0, 21, 1, 19, 0); push(0, 28, 2, 19, 0); push(1, 34, 2, 19, 0);
      release_start();
      to_before_edge(s_edge + 20);
      BusyFlag = 1'b0;
      drain("busy", 80);

      // 3: count 0: immediate done, no pulse, never active.
      active_seen = 1'b0;
      start_burst(0, 7);
      push(1, 1, 0, 0, 0);
      release_start();
      drain("zero", 20);
      check("zero_active_seen", int'(active_seen), 0);

      // 4: count 5, gap 8, abort in GAP after the second pulse (sampled at S+16).
      start_burst(5, 8);
      push(0, 2, 1, 0, 0); push(0, 13, 2, 0, 0); push(1, 17, 2, 0, 1);
      release_start();
      to_before_edge(s_edge + 16);
      burst_abort = 1'b1;
      @(negedge gclk_40m);
      burst_abort = 1'b0;
      drain("abort", 40);
      check("abort_sticky", int'(burst_aborted), 1);
      check("abort_trig", int'(trig_issued), 2);

      // 5: next start clears the abort status and the trigger count.
      start_burst(1, 2);
      push(0, 2, 1, 0, 0); push(1, 6, 1, 0, 0);
      release_start();
      check("restart_abrt_clr", int'(burst_aborted), 0);
      check("restart_trig_clr", int'(trig_issued), 0);
      drain("restart", 30);

      // 6: start and a new count mid-burst are ignored; original count 3 completes.
      start_burst(3, 5);
      push(0, 2, 1, 0, 0); push(0, 10, 2, 0, 0); push(0, 18, 3, 0, 0); push(1, 25, 3, 0, 0);
      release_start();
      to_before_edge(s_edge + 5);
      burst_count = CW'(7);
      burst_gap   = CW'(1);
      burst_start = 1'b1;
      @(negedge gclk_40m);
      burst_start = 1'b0;
      drain("midstart", 60);

      // 7: reset in GAP ends the burst silently; a fresh start then repeats scenario 1.
      start_burst(3, 10);
      push(0, 2, 1, 0, 0);
      release_start();
      to_before_edge(s_edge + 5);
      reset = 1'b1;
      @(negedge gclk_40m);
      check_all_zero("mid_reset");
      reset = 1'b0;
      repeat (40) @(negedge gclk_40m);
      drain("post_reset", 10);
      start_burst(3, 10);
      push(0, 2, 1, 0, 0); push(0, 15, 2, 0, 0); push(0, 28, 3, 0, 0); push(1, 40, 3, 0, 0);
      release_start();
      drain("rerun", 80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
